// File: rtl/par_data_pkg.sv
// par_data_pkg: shared state encoding and defaults for par_data_req_ctrl
package par_data_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ASK  = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_OUT  = 3'd4
  } state_t;
  localparam int DW_DEF = 4;
  localparam int NIB_DEF = 4;
  localparam int WCNT_W = 16;
endpackage

// File: rtl/par_data_req_ctrl_if.sv
// par_data_req_ctrl_if: control, source and consumer signals of par_data_req_ctrl
// master: controller side (drives ask_for_data, word, word_valid, busy, nib_cnt[, word_cnt])
// slave: environment side (drives start, clr, data, word_ready)
// word_cnt exists only when PAR_DATA_WORD_CNT_EN is defined
interface par_data_req_ctrl_if
  import par_data_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NIB = NIB_DEF
);
  logic start;
  logic clr;
  logic [DW-1:0] data;
  logic ask_for_data;
  logic [DW*NIB-1:0] word;
  logic word_valid;
  logic word_ready;
  logic busy;
  logic [$clog2(NIB)-1:0] nib_cnt;
`ifdef PAR_DATA_WORD_CNT_EN
  logic [WCNT_W-1:0] word_cnt;
`endif
  modport master (
    input start, clr, data, word_ready,
    output ask_for_data, word, word_valid, busy, nib_cnt
`ifdef PAR_DATA_WORD_CNT_EN
    , output word_cnt
`endif
  );
  modport slave (
    output start, clr, data, word_ready,
    input ask_for_data, word, word_valid, busy, nib_cnt
`ifdef PAR_DATA_WORD_CNT_EN
    , input word_cnt
`endif
  );
endinterface

// File: rtl/par_data_req_ctrl_cyc_timer.sv
// cyc_timer: loadable down-counter, done when it reaches zero
// ports: sclk, rst (async active-low), load, val (load value), done
module cyc_timer #(
  parameter int TW = 4
) (
  input  logic sclk,
  input  logic rst,
  input  logic load,
  input  logic [TW-1:0] val,
  output logic done
);
  logic [TW-1:0] cnt;
  assign done = cnt == '0;
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (!done) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/par_data_req_ctrl.sv
// par_data_req_ctrl: issues ask_for_data pulses, packs NIB nibbles MSB-first into a word, hands it out valid/ready
// ports: sclk, rst (async active-low), bus (par_data_req_ctrl_if.master)
// optional PAR_DATA_WORD_CNT_EN adds the 16-bit accepted-word counter bus.word_cnt
module par_data_req_ctrl
  import par_data_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NIB = NIB_DEF,
  parameter int DATA_DLY = 1,
  parameter int GAP = 1
) (
  input logic sclk,
  input logic rst,
  par_data_req_ctrl_if.master bus
);
  localparam int W = DW*NIB;
  localparam int CW = $clog2(NIB);
  localparam int TW = $clog2((DATA_DLY > GAP ? DATA_DLY : GAP) + 1);
  state_t state, state_nx;
  logic [W-1:0] shreg;
  logic [TW-1:0] tm_val;
  logic tm_load, tm_done, cap, last;
  assign last = bus.nib_cnt == CW'(NIB-1);
  cyc_timer #(.TW(TW)) u_tmr (
    .sclk(sclk),
    .rst(rst),
    .load(tm_load),
    .val(tm_val),
    .done(tm_done)
  );
  // Timer is loaded with N-1 on entry so the state lasts exactly N cycles.
  always_comb begin
    state_nx = state;
    cap = 1'b0;
    tm_load = 1'b0;
    tm_val = TW'(DATA_DLY-1);
    if (bus.clr) state_nx = S_IDLE;
    else begin
      case (state)
        S_IDLE: state_nx = bus.start ? S_ASK : S_IDLE;
        S_ASK: begin
          if (DATA_DLY == 0) cap = 1'b1;
          else begin
            state_nx = S_WAIT;
            tm_load = 1'b1;
          end
        end
        S_WAIT: cap = tm_done;
        S_GAP: state_nx = tm_done ? S_ASK : S_GAP;
        S_OUT: state_nx = bus.word_ready ? (bus.start ? S_ASK : S_IDLE) : S_OUT;
        default: state_nx = S_IDLE;
      endcase
      if (cap) begin
        state_nx = last ? S_OUT : S_GAP;
        tm_load = !last;
        tm_val = TW'(GAP-1);
      end
    end
  end
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      bus.ask_for_data <= 1'b0;
      bus.busy <= 1'b0;
      bus.word_valid <= 1'b0;
      bus.word <= '0;
      bus.nib_cnt <= '0;
      shreg <= '0;
    end else begin
      bus.ask_for_data <= state_nx == S_ASK;
      bus.busy <= state_nx != S_IDLE;
      if (bus.clr) begin
        bus.word_valid <= 1'b0;
        bus.nib_cnt <= '0;
        shreg <= '0;
      end else if (cap) begin
        shreg <= {shreg[W-DW-1:0], bus.data};
        bus.nib_cnt <= last ? '0 : bus.nib_cnt + 1'b1;
        if (last) begin
          bus.word <= {shreg[W-DW-1:0], bus.data};
          bus.word_valid <= 1'b1;
        end
      end else if (state == S_OUT && bus.word_ready) bus.word_valid <= 1'b0;
    end
  end
`ifdef PAR_DATA_WORD_CNT_EN
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) bus.word_cnt <= '0;
    else if (bus.word_valid && bus.word_ready && !bus.clr) bus.word_cnt <= bus.word_cnt + 1'b1;
  end
`endif
endmodule
